// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns the PC, fetches over req/ack,
// evaluates ARM-style condition codes and sequences ALU, data memory and writeback.
`timescale 1ns/1ps

module cpu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      OPC_LDR  = 4'b1100,
  parameter logic [3:0]      OPC_STR  = 4'b1101,
  parameter logic [3:0]      OPC_B    = 4'b1010
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [3:0]      cond,
  output logic [3:0]      opcode,
  output logic            s,
  output logic [3:0]      rd,
  output logic [3:0]      rs2,
  output logic [3:0]      rs1,
  output logic [4:0]      shamt,
  output logic [15:0]     imm16,
  output logic            alu_en,
  input  logic [3:0]      new_flag,
  output logic [3:0]      flags,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            reg_we,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state_q, state_d, next_fetch;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, br_off;
  logic [31:0]     instr_q, instr_d;
  logic [3:0]      flags_q, flags_d;
  logic            imem_req_q, alu_en_q, dmem_req_q, dmem_we_q, reg_we_q, halted_q;
  logic            is_ls, unused_low;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cy;
      4'h3:    cond_pass = !cy;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cy && !z;
      4'h9:    cond_pass = !cy || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign cond   = instr_q[31:28];
  assign opcode = instr_q[27:24];
  assign s      = instr_q[23];
  assign rd     = instr_q[22:19];
  assign rs2    = instr_q[18:15];
  assign rs1    = instr_q[14:11];
  assign shamt  = instr_q[10:6];
  assign imm16  = instr_q[18:3];
  assign unused_low = ^instr_q[2:0];

  assign pc_inc     = pc_q + PC_W'(1);
  // Sign-extend (or truncate) the branch offset to PC width; the add wraps naturally.
  assign br_off     = PC_W'($signed(imm16));
  assign is_ls      = (opcode == OPC_LDR) || (opcode == OPC_STR);
  assign next_fetch = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cond == 4'hF && opcode == 4'hF) begin
          state_d = S_HALT;
        end else if (cond_pass(cond, flags_q)) begin
          state_d = S_EXEC;
        end else begin
          pc_d    = pc_inc;
          state_d = next_fetch;
        end
      end
      S_EXEC: begin
        if (s && !is_ls && opcode != OPC_B) flags_d = new_flag;
        if (opcode == OPC_B) begin
          pc_d    = pc_inc + br_off;
          state_d = next_fetch;
        end else if (is_ls) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (opcode == OPC_STR) begin
            pc_d    = pc_inc;
            state_d = next_fetch;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = next_fetch;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly in its own state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      flags_q    <= '0;
      imem_req_q <= 1'b0;
      alu_en_q   <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      flags_q    <= flags_d;
      imem_req_q <= (state_d == S_FETCH);
      alu_en_q   <= (state_d == S_EXEC);
      dmem_req_q <= (state_d == S_MEM);
      dmem_we_q  <= (state_d == S_MEM) && (instr_d[27:24] == OPC_STR);
      reg_we_q   <= (state_d == S_WB);
      halted_q   <= (state_d == S_HALT);
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign alu_en    = alu_en_q;
  assign flags     = flags_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign reg_we    = reg_we_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a writeback scoreboard keyed on instruction pc.
`timescale 1ns/1ps

module tb_cpu_sequencer;
  localparam int PC_W = 8;
  localparam logic [31:0] HALT_W = 32'hFF00_0000;
  localparam logic [31:0] ALU_W  = 32'hE000_0000;
  localparam logic [31:0] SETF_W = 32'hE080_0000;

  logic            Clk = 1'b0;
  logic            Reset, run;
  logic            imem_req, imem_ack;
  logic [PC_W-1:0] imem_addr, pc;
  logic [31:0]     imem_rdata;
  logic [3:0]      cond, opcode, rd, rs2, rs1, new_flag, flags;
  logic            s, alu_en, dmem_req, dmem_we, dmem_ack, reg_we, halted;
  logic [4:0]      shamt;
  logic [15:0]     imm16;

  logic [31:0] imem [256];
  logic [3:0]  flag_tab [256];
  logic        imem_ack_en, dmem_ack_en;

  int          n_checks = 0, n_pass = 0, cyc = 0;
  int          wb_seen = 0, wb_mark = 0, first_wb_cyc = 0, last_wb_cyc = 0;
  logic [7:0]  wb_q [$];

  assign imem_ack   = imem_req & imem_ack_en;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req & dmem_ack_en;
  assign new_flag   = flag_tab[pc];

  always #5 Clk = ~Clk;

  cpu_sequencer #(.PC_W(PC_W)) dut (
    .Clk(Clk), .Reset(Reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .cond(cond), .opcode(opcode), .s(s), .rd(rd), .rs2(rs2), .rs1(rs1),
    .shamt(shamt), .imm16(imm16), .alu_en(alu_en), .new_flag(new_flag), .flags(flags),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_we(reg_we), .pc(pc), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to the next falling edge and run the scoreboard on what the DUT shows there.
  task automatic tick;
    @(negedge Clk);
    cyc++;
    if (!Reset) begin
      check("strobe_excl", 32'($countones({imem_req, alu_en, dmem_req, reg_we}) <= 1), 32'd1);
      if (reg_we) begin
        if (wb_seen == wb_mark) first_wb_cyc = cyc;
        last_wb_cyc = cyc;
        wb_seen++;
        check("wb_expected", 32'(wb_q.size() != 0), 32'd1);
        if (wb_q.size() != 0) check("wb_pc", 32'(pc), 32'(wb_q.pop_front()));
      end
    end
  endtask

  task automatic do_reset;
    Reset = 1'b1; run = 1'b0; imem_ack_en = 1'b0; dmem_ack_en = 1'b0;
    tick; tick;
    Reset = 1'b0;
    wb_q.delete();
  endtask

  task automatic wait_halt(input int budget);
    for (int k = 0; k < budget && !halted; k++) tick;
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < 256; i++) begin
      imem[i] = w;
      flag_tab[i] = 4'h0;
    end
  endtask

  function automatic logic [31:0] br(input logic [15:0] imm);
    return {8'hEA, 5'd0, imm, 3'd0};
  endfunction

  function automatic bit exp_pass(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    logic [15:0] t;
    t = {1'b0, 1'b1, z | (n ^ v), !z & !(n ^ v), n ^ v, !(n ^ v), !cy | z, cy & !z,
         !v, v, !n, n, !cy, cy, !z, z};
    return t[c];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] fv [7];
    int a;
    fv = '{4'h0, 4'h4, 4'h2, 4'h8, 4'h1, 4'h9, 4'h6};

    // Reset state
    Reset = 1'b1; run = 1'b0; imem_ack_en = 1'b0; dmem_ack_en = 1'b0;
    fill(HALT_W);
    tick;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_strobes", {27'd0, imem_req, alu_en, dmem_req, dmem_we, reg_we}, 32'd0);
    check("rst_halt_flags", {27'd0, halted, flags}, 32'd0);
    check("rst_instr", {24'd0, cond, opcode}, 32'd0);

    // 1: AL ALU op everywhere, pc wraps 255 -> 0
    fill(ALU_W);
    do_reset;
    for (int i = 0; i < 256; i++) wb_q.push_back(8'(i));
    wb_q.push_back(8'd0);
    wb_mark = wb_seen;
    run = 1'b1; imem_ack_en = 1'b1;
    for (int k = 0; k < 100 && (wb_seen - wb_mark) < 3; k++) tick;
    imem[1] = HALT_W;
    wait_halt(1200);
    check("t1_span", 32'(last_wb_cyc - first_wb_cyc), 32'd1024);
    check("t1_pc_halt", 32'(pc), 32'd1);
    check("t1_sb_empty", 32'(wb_q.size()), 32'd0);

    // 2: EQ fails with Z=0, then executes after Z is set
    fill(HALT_W);
    imem[0] = 32'h0000_0000;
    imem[1] = SETF_W; flag_tab[1] = 4'b0100;
    imem[2] = 32'h0000_0000;
    do_reset;
    wb_q.push_back(8'd1); wb_q.push_back(8'd2);
    run = 1'b1; imem_ack_en = 1'b1;
    tick; check("t2_fetch0", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'd0});
    tick; check("t2_dec_noalu", {23'd0, alu_en, pc}, 32'd0);
    tick; check("t2_pc_plus1", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'd1});
    wait_halt(40);
    check("t2_flags", 32'(flags), 32'h4);
    check("t2_pc", 32'(pc), 32'd3);
    check("t2_sb_empty", 32'(wb_q.size()), 32'd0);

    // 2b: every condition code against a spread of flag values
    fill(HALT_W);
    do_reset;
    a = 0;
    for (int fi = 0; fi < 7; fi++) begin
      for (int c = 0; c < 16; c++) begin
        imem[a] = SETF_W; flag_tab[a] = fv[fi];
        wb_q.push_back(8'(a));
        imem[a + 1] = {4'(c), 28'h0}; flag_tab[a + 1] = ~fv[fi];
        if (exp_pass(4'(c), fv[fi])) wb_q.push_back(8'(a + 1));
        a += 2;
      end
    end
    run = 1'b1; imem_ack_en = 1'b1;
    wait_halt(2000);
    check("t2b_pc", 32'(pc), 32'd224);
    check("t2b_flags", 32'(flags), 32'h6);
    check("t2b_sb_empty", 32'(wb_q.size()), 32'd0);

    // 3: s=1 updates flags; s=0 and LDR with s=1 leave them alone
    fill(HALT_W);
    imem[0] = SETF_W;       flag_tab[0] = 4'b1001;
    imem[1] = ALU_W;        flag_tab[1] = 4'b0110;
    imem[2] = 32'hEC80_0000; flag_tab[2] = 4'b0110;
    do_reset;
    wb_q.push_back(8'd0); wb_q.push_back(8'd1); wb_q.push_back(8'd2);
    run = 1'b1; imem_ack_en = 1'b1; dmem_ack_en = 1'b1;
    tick; tick; tick;
    check("t3_flags_in_exec", 32'(flags), 32'h0);
    tick;
    check("t3_flags_after_exec", 32'(flags), 32'h9);
    wait_halt(40);
    check("t3_flags_final", 32'(flags), 32'h9);
    check("t3_pc", 32'(pc), 32'd3);
    check("t3_sb_empty", 32'(wb_q.size()), 32'd0);

    // 4: relative branches, backward and wrapping forward
    fill(HALT_W);
    imem[0] = br(16'd9);
    imem[10] = br(16'hFFFB);
    do_reset;
    run = 1'b1; imem_ack_en = 1'b1;
    tick; tick; tick;
    check("t4_exec_alu", {31'd0, alu_en}, 32'd1);
    tick; check("t4_fetch10", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'd10});
    tick; tick; tick;
    check("t4_fetch6", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'd6});
    tick; tick;
    check("t4_halt6", {23'd0, halted, pc}, {23'd0, 1'b1, 8'd6});
    imem[10] = br(16'h00F8);
    do_reset;
    run = 1'b1; imem_ack_en = 1'b1;
    wait_halt(40);
    check("t4_wrap_pc", 32'(pc), 32'd3);

    // 5: LDR with delayed ack, then STR
    fill(HALT_W);
    imem[0] = 32'hEC00_0000;
    imem[1] = 32'hED00_0000;
    do_reset;
    wb_q.push_back(8'd0);
    run = 1'b1; imem_ack_en = 1'b1;
    tick; tick; tick;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("t5_ldr_mem", {30'd0, dmem_req, dmem_we}, 32'b10);
      if (k == 3) dmem_ack_en = 1'b1;
    end
    tick;
    check("t5_ldr_wb", {30'd0, reg_we, dmem_req}, 32'b10);
    dmem_ack_en = 1'b0;
    tick; tick; tick; tick;
    check("t5_str_mem", {30'd0, dmem_req, dmem_we}, 32'b11);
    dmem_ack_en = 1'b1;
    tick;
    check("t5_str_next", {22'd0, reg_we, imem_req, imem_addr}, {22'd0, 1'b0, 1'b1, 8'd2});
    wait_halt(20);
    check("t5_sb_empty", 32'(wb_q.size()), 32'd0);

    // 6: halt freezes pc; async reset aborts a stalled fetch
    for (int k = 0; k < 20; k++) begin
      tick;
      check("t6_frozen", {23'd0, halted, pc}, {23'd0, 1'b1, 8'd2});
    end
    fill(ALU_W);
    do_reset;
    wb_q.push_back(8'd0);
    run = 1'b1; imem_ack_en = 1'b1;
    for (int k = 0; k < 20 && !(imem_req && imem_addr == 8'd1); k++) tick;
    imem_ack_en = 1'b0;
    check("t6_reach_fetch1", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'd1});
    tick; tick; tick;
    check("t6_stall_hold", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'd1});
    #2 Reset = 1'b1;
    #1;
    check("t6_async_req", 32'(imem_req), 32'd0);
    check("t6_async_pc", {23'd0, halted, pc}, 32'd0);
    check("t6_sb_empty", 32'(wb_q.size()), 32'd0);
    tick;
    Reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Parametrised multi-cycle fetch/decode/execute controller that replaces bench-driven instruction stepping in the CPU top. It owns the program counter and fetches from instruction RAM over a req/ack handshake. It decodes the 32-bit instruction fields, evaluates the condition code against the stored flags, and sequences the ALU, data memory and register-bank writeback. Branch, halt and memory wait-state handling are new relative to the current top.

Parameters:
PC_W, 8, program counter / instruction address width
RESET_PC, 0, PC value after reset
OPC_LDR, 4'b1100, opcode for load (memory read, writeback)
OPC_STR, 4'b1101, opcode for store (memory write, no writeback)
OPC_B, 4'b1010, opcode for relative branch

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high
run  in  1  start/continue execution; sampled in IDLE
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  instruction word
cond, opcode  out  4 each  instr[31:28], instr[27:24]
s  out  1  instr[23], flag-update enable
rd, rs2, rs1  out  4 each  instr[22:19], [18:15], [14:11]
shamt  out  5  instr[10:6]
imm16  out  16  instr[18:3]
alu_en  out  1  execute strobe to ALU
new_flag  in  4  ALU flags {N,Z,C,V}
flags  out  4  architectural flags register
dmem_req  out  1  data memory request
dmem_we  out  1  1=store, 0=load
dmem_ack  in  1  data memory done
reg_we  out  1  register-bank write strobe
pc  out  PC_W  current program counter
halted  out  1  HALT state indicator

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, instr reg=0, flags=0, all strobes 0, halted=0.
- Decoded-field outputs are driven combinationally from the latched instruction register.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, latch imem_rdata at the edge and go to DECODE. With no ack, hold req/addr and wait indefinitely.
- DECODE (1 cycle): evaluate cond against flags, ARM encoding:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F never
  - cond=F with opcode=F -> HALT.
  - Condition false -> pc<=pc+1, go to FETCH.
  - Condition true -> go to EXEC.
- EXEC (1 cycle): alu_en=1.
  - If s=1 and opcode is neither LDR, STR nor B, flags<=new_flag.
  - OPC_B -> pc<=pc+1+sign-extend(imm16), truncated mod 2^PC_W, then FETCH. No reg_we.
  - LDR/STR -> MEM.
  - Otherwise -> WB.
- MEM: dmem_req=1; dmem_we=1 for STR, 0 for LDR. Hold until dmem_ack=1. Then STR goes to FETCH with pc+1; LDR goes to WB.
- WB (1 cycle): reg_we=1, pc<=pc+1, then FETCH. If run=0 at that point, go to IDLE instead; the same run=0 exit applies at every transition into FETCH.
- HALT: halted=1; pc frozen; leaves only on Reset.
- Strobes (imem_req, alu_en, dmem_req, reg_we) are high only in their own state and never overlap.
- pc increments wrap modulo 2^PC_W: pc=2^PC_W-1 plus 1 gives 0.
- Latency with zero-wait acks:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB)
  - LDR: 5 cycles
  - STR: 4 cycles
  - Taken branch: 3 cycles
  - Condition fail: 2 cycles
- Reset asserted mid-MEM or mid-FETCH aborts immediately; the request drops asynchronously.

Test Plan:
1. Reset, run=1, imem zero-wait with word 32'hE000_0000 (AL, opcode 0) at every address -> reg_we pulses every 4th cycle; pc goes 0,1,2..., 255 then 0.
2. flags=0, instr 32'h0xxxxxxx (EQ) -> no alu_en or reg_we; pc+1 two cycles after fetch ack. With flags Z=1 (4'b0100) the same instr executes.
3. EXEC with s=1, new_flag=4'b1001 -> flags=4'b1001 after EXEC. With s=0, flags unchanged.
4. At pc=10, OPC_B with AL and imm16=16'hFFFB (-5) -> next imem_addr=6. With imm16=16'h00F8 at pc=10 -> addr 3 (wrap mod 256).
5. LDR with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then one reg_we pulse. STR -> dmem_we=1, no reg_we.
6. Fetch 32'hFF00_0000 -> halted=1, pc frozen for 20 cycles. Then assert Reset during a stalled FETCH -> imem_req=0 at once, pc=RESET_PC.
